// File: rtl/fetch_decode_if.sv
// Operand bundle and completion handshake between fetch_decode and the execute stage.
// master = fetch_decode side, slave = execute side.
interface fetch_decode_if;
  logic        exec_valid;
  logic [5:0]  opecode;
  logic [4:0]  rs_no;
  logic [4:0]  rt_no;
  logic [4:0]  rd_no;
  logic [15:0] offset;
  logic [31:0] pc;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        fmode1;
  logic        fmode2;
  logic        exec_done;
  logic        exec_pcenable;
  logic [31:0] exec_next_pc;

  modport master (
    output exec_valid, opecode, rs_no, rt_no, rd_no, offset, pc, rs, rt, fmode1, fmode2,
    input  exec_done, exec_pcenable, exec_next_pc
  );

  modport slave (
    input  exec_valid, opecode, rs_no, rt_no, rd_no, offset, pc, rs, rt, fmode1, fmode2,
    output exec_done, exec_pcenable, exec_next_pc
  );
endinterface

// File: rtl/fetch_decode.sv
// Fetch/decode front end: FETCH -> DECODE -> READ -> ISSUE, holding the operand bundle until execute reports done.
// Optional macro FETCH_HALT_EN adds a terminal HALT state on opcode 6'h3F and the halted output.
module fetch_decode #(
  parameter int          IMEM_AW  = 15,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [5:0]  FOP      = 6'h11,
  parameter logic [5:0]  FSTORE   = 6'h39
) (
  input  logic               clk,
  input  logic               rst,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [4:0]         rf_raddr1,
  output logic [4:0]         rf_raddr2,
  output logic               rf_fmode1,
  output logic               rf_fmode2,
  input  logic [31:0]        rf_rdata1,
  input  logic [31:0]        rf_rdata2,
`ifdef FETCH_HALT_EN
  output logic               halted,
`endif
  fetch_decode_if.master     exec
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_READ,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t      state;
  logic [31:0] pc_reg;
  logic [31:0] instr_q;
  logic [1:0]  dec_fmode;

  function automatic logic [1:0] fmode_of(input logic [5:0] op);
    if (op == FOP)         return 2'b11;
    else if (op == FSTORE) return 2'b01;
    else                   return 2'b00;
  endfunction

  // The BRAMs are synchronous, so addresses are driven in the cycle before the data is consumed.
  assign imem_addr = pc_reg[IMEM_AW-1:0];
  assign dec_fmode = fmode_of(imem_rdata[31:26]);

  always_comb begin
    rf_raddr1 = '0;
    rf_raddr2 = '0;
    rf_fmode1 = 1'b0;
    rf_fmode2 = 1'b0;
    if (state == S_DECODE) begin
      rf_raddr1 = imem_rdata[25:21];
      rf_raddr2 = imem_rdata[20:16];
      rf_fmode1 = dec_fmode[1];
      rf_fmode2 = dec_fmode[0];
    end
  end

  assign exec.opecode = instr_q[31:26];
  assign exec.rs_no   = instr_q[25:21];
  assign exec.rt_no   = instr_q[20:16];
  assign exec.rd_no   = instr_q[15:11];
  assign exec.offset  = instr_q[15:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_FETCH;
      pc_reg          <= RESET_PC;
      instr_q         <= '0;
      exec.exec_valid <= 1'b0;
      exec.pc         <= RESET_PC;
      exec.rs         <= '0;
      exec.rt         <= '0;
      exec.fmode1     <= 1'b0;
      exec.fmode2     <= 1'b0;
`ifdef FETCH_HALT_EN
      halted          <= 1'b0;
`endif
    end else begin
      case (state)
        S_FETCH: begin
          state <= S_DECODE;
        end
        S_DECODE: begin
`ifdef FETCH_HALT_EN
          if (imem_rdata[31:26] == 6'h3F) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            instr_q     <= imem_rdata;
            exec.fmode1 <= dec_fmode[1];
            exec.fmode2 <= dec_fmode[0];
            state       <= S_READ;
          end
`else
          instr_q     <= imem_rdata;
          exec.fmode1 <= dec_fmode[1];
          exec.fmode2 <= dec_fmode[0];
          state       <= S_READ;
`endif
        end
        S_READ: begin
          exec.rs         <= rf_rdata1;
          exec.rt         <= rf_rdata2;
          exec.pc         <= pc_reg;
          exec.exec_valid <= 1'b1;
          state           <= S_ISSUE;
        end
        S_ISSUE: begin
          // Branch targets are taken verbatim; the sequential path wraps modulo 2^32.
          if (exec.exec_done) begin
            pc_reg          <= exec.exec_pcenable ? exec.exec_next_pc : pc_reg + 32'd1;
            exec.exec_valid <= 1'b0;
            state           <= S_FETCH;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode.sv
// Directed self-checking bench for fetch_decode with behavioural instruction BRAM and register files.
// A second instance with RESET_PC = 32'hFFFF_FFFF checks PC wraparound.
module tb_fetch_decode;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] imem [0:32767];
  logic [31:0] int_rf [0:31];
  logic [31:0] fp_rf [0:31];

  int assertCount = 0;
  int failCount   = 0;

  logic [14:0] imem_addr, imem_addr_w;
  logic [31:0] imem_rdata, imem_rdata_w;
  logic [4:0]  rf_raddr1, rf_raddr2, rf_raddr1_w, rf_raddr2_w;
  logic        rf_fmode1, rf_fmode2, rf_fmode1_w, rf_fmode2_w;
  logic [31:0] rf_rdata1, rf_rdata2, rf_rdata1_w, rf_rdata2_w;
`ifdef FETCH_HALT_EN
  logic        halted, halted_w;
`endif

  fetch_decode_if bus ();
  fetch_decode_if bus_w ();

  fetch_decode #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_fmode1(rf_fmode1), .rf_fmode2(rf_fmode2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
`ifdef FETCH_HALT_EN
    .halted(halted),
`endif
    .exec(bus)
  );

  fetch_decode #(.RESET_PC(32'hFFFF_FFFF)) dut_w (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w),
    .rf_raddr1(rf_raddr1_w), .rf_raddr2(rf_raddr2_w),
    .rf_fmode1(rf_fmode1_w), .rf_fmode2(rf_fmode2_w),
    .rf_rdata1(rf_rdata1_w), .rf_rdata2(rf_rdata2_w),
`ifdef FETCH_HALT_EN
    .halted(halted_w),
`endif
    .exec(bus_w)
  );

  // Synchronous-read memories: data appears one cycle after the address.
  always @(posedge clk) begin
    imem_rdata   <= imem[imem_addr];
    rf_rdata1    <= rf_fmode1 ? fp_rf[rf_raddr1] : int_rf[rf_raddr1];
    rf_rdata2    <= rf_fmode2 ? fp_rf[rf_raddr2] : int_rf[rf_raddr2];
    imem_rdata_w <= imem[imem_addr_w];
    rf_rdata1_w  <= rf_fmode1_w ? fp_rf[rf_raddr1_w] : int_rf[rf_raddr1_w];
    rf_rdata2_w  <= rf_fmode2_w ? fp_rf[rf_raddr2_w] : int_rf[rf_raddr2_w];
  end

  // The wrap instance follows the main done pulses but never branches.
  assign bus_w.exec_done     = bus.exec_done;
  assign bus_w.exec_pcenable = 1'b0;
  assign bus_w.exec_next_pc  = 32'h0;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic done, input logic pcen, input logic [31:0] next_pc);
    bus.exec_done     = done;
    bus.exec_pcenable = pcen;
    bus.exec_next_pc  = next_pc;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) imem[i] = 32'h0;
    for (int i = 0; i < 32; i++) begin
      int_rf[i] = 32'h0;
      fp_rf[i]  = 32'h0;
    end
    imem[0]       = 32'h2022_0005;
    imem[1]       = 32'hE464_0010;
    imem[32'h40]  = 32'h44A6_3800;
    imem[32'h41]  = 32'hFC20_0000;
    imem[15'h7FFF] = 32'h2022_0005;
    int_rf[1] = 32'd7;
    int_rf[2] = 32'd9;
    int_rf[3] = 32'h33;
    fp_rf[4]  = 32'hF4F4;
    fp_rf[5]  = 32'h55;
    fp_rf[6]  = 32'h66;

    applyStimulus(1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;

    // Cycle 0 after reset: FETCH
    checkOutput("reset_valid", {31'b0, bus.exec_valid}, 32'd0);
    checkOutput("reset_pc", bus.pc, 32'h0);
    checkOutput("reset_imem_addr", {17'b0, imem_addr}, 32'h0);
    checkOutput("reset_opecode", {26'b0, bus.opecode}, 32'h0);
    checkOutput("reset_rs", bus.rs, 32'h0);
    checkOutput("reset_rf_raddr1", {27'b0, rf_raddr1}, 32'h0);
    checkOutput("wrap_reset_pc", bus_w.pc, 32'hFFFF_FFFF);
    checkOutput("wrap_reset_imem_addr", {17'b0, imem_addr_w}, 32'h7FFF);

    tick(1);
    checkOutput("dec0_raddr1", {27'b0, rf_raddr1}, 32'd1);
    checkOutput("dec0_raddr2", {27'b0, rf_raddr2}, 32'd2);
    checkOutput("dec0_fmodes", {30'b0, rf_fmode1, rf_fmode2}, 32'd0);

    tick(1);
    checkOutput("read0_valid", {31'b0, bus.exec_valid}, 32'd0);
    tick(1);
    checkOutput("iss0_valid", {31'b0, bus.exec_valid}, 32'd1);
    checkOutput("iss0_opecode", {26'b0, bus.opecode}, 32'h08);
    checkOutput("iss0_rs_no", {27'b0, bus.rs_no}, 32'd1);
    checkOutput("iss0_rt_no", {27'b0, bus.rt_no}, 32'd2);
    checkOutput("iss0_offset", {16'b0, bus.offset}, 32'h0005);
    checkOutput("iss0_rs", bus.rs, 32'd7);
    checkOutput("iss0_rt", bus.rt, 32'd9);
    checkOutput("iss0_pc", bus.pc, 32'h0);
    checkOutput("iss0_fmodes", {30'b0, bus.fmode1, bus.fmode2}, 32'd0);
    checkOutput("wrap_iss0_pc", bus_w.pc, 32'hFFFF_FFFF);
    checkOutput("wrap_iss0_rs", bus_w.rs, 32'd7);

    tick(20);
    checkOutput("hold_valid", {31'b0, bus.exec_valid}, 32'd1);
    checkOutput("hold_opecode", {26'b0, bus.opecode}, 32'h08);
    checkOutput("hold_offset", {16'b0, bus.offset}, 32'h0005);
    checkOutput("hold_rs", bus.rs, 32'd7);
    checkOutput("hold_rt", bus.rt, 32'd9);
    checkOutput("hold_pc", bus.pc, 32'h0);

    applyStimulus(1'b1, 1'b0, 32'h0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("done0_valid_fall", {31'b0, bus.exec_valid}, 32'd0);
    checkOutput("done0_imem_addr", {17'b0, imem_addr}, 32'd1);
    checkOutput("wrap_next_imem_addr", {17'b0, imem_addr_w}, 32'h0);

    tick(1);
    checkOutput("fstore_raddr1", {27'b0, rf_raddr1}, 32'd3);
    checkOutput("fstore_raddr2", {27'b0, rf_raddr2}, 32'd4);
    checkOutput("fstore_rf_fmode1", {31'b0, rf_fmode1}, 32'd0);
    checkOutput("fstore_rf_fmode2", {31'b0, rf_fmode2}, 32'd1);

    tick(2);
    checkOutput("iss1_valid", {31'b0, bus.exec_valid}, 32'd1);
    checkOutput("iss1_opecode", {26'b0, bus.opecode}, 32'h39);
    checkOutput("iss1_rs", bus.rs, 32'h33);
    checkOutput("iss1_rt", bus.rt, 32'hF4F4);
    checkOutput("iss1_fmodes", {30'b0, bus.fmode1, bus.fmode2}, 32'd1);
    checkOutput("iss1_pc", bus.pc, 32'd1);
    checkOutput("wrap_iss1_pc", bus_w.pc, 32'h0);

    // Done in the first ISSUE cycle with a branch to 0x40
    applyStimulus(1'b1, 1'b1, 32'h40);
    tick(1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("branch_valid_fall", {31'b0, bus.exec_valid}, 32'd0);
    checkOutput("branch_imem_addr", {17'b0, imem_addr}, 32'h40);

    tick(1);
    checkOutput("fop_rf_fmodes", {30'b0, rf_fmode1, rf_fmode2}, 32'd3);
    checkOutput("fop_raddr1", {27'b0, rf_raddr1}, 32'd5);

    tick(2);
    checkOutput("iss2_valid", {31'b0, bus.exec_valid}, 32'd1);
    checkOutput("iss2_pc", bus.pc, 32'h40);
    checkOutput("iss2_rs", bus.rs, 32'h55);
    checkOutput("iss2_rt", bus.rt, 32'h66);
    checkOutput("iss2_rd_no", {27'b0, bus.rd_no}, 32'd7);
    checkOutput("iss2_offset", {16'b0, bus.offset}, 32'h3800);
    checkOutput("iss2_fmodes", {30'b0, bus.fmode1, bus.fmode2}, 32'd3);

    applyStimulus(1'b1, 1'b0, 32'h0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("seq_imem_addr", {17'b0, imem_addr}, 32'h41);
    tick(3);

`ifdef FETCH_HALT_EN
    checkOutput("halt_flag", {31'b0, halted}, 32'd1);
    checkOutput("halt_valid", {31'b0, bus.exec_valid}, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h40);
    tick(1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    tick(10);
    checkOutput("halt_valid_late", {31'b0, bus.exec_valid}, 32'd0);
    checkOutput("halt_pc_frozen", {17'b0, imem_addr}, 32'h41);
    checkOutput("halt_flag_late", {31'b0, halted}, 32'd1);
`else
    checkOutput("op3f_valid", {31'b0, bus.exec_valid}, 32'd1);
    checkOutput("op3f_opecode", {26'b0, bus.opecode}, 32'h3F);
    checkOutput("op3f_pc", bus.pc, 32'h41);
    checkOutput("op3f_rs", bus.rs, 32'd7);
    checkOutput("op3f_rt", bus.rt, 32'd0);
`endif

    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkOutput("rst_valid", {31'b0, bus.exec_valid}, 32'd0);
    checkOutput("rst_pc", bus.pc, 32'h0);
    checkOutput("rst_imem_addr", {17'b0, imem_addr}, 32'h0);
    checkOutput("rst_opecode", {26'b0, bus.opecode}, 32'h0);
    checkOutput("rst_rs", bus.rs, 32'h0);
`ifdef FETCH_HALT_EN
    checkOutput("rst_halted", {31'b0, halted}, 32'd0);
`endif

    // Done/branch asserted outside ISSUE must be ignored
    applyStimulus(1'b1, 1'b1, 32'h123);
    tick(3);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("ignore_valid", {31'b0, bus.exec_valid}, 32'd1);
    checkOutput("ignore_pc", bus.pc, 32'h0);
    checkOutput("ignore_opecode", {26'b0, bus.opecode}, 32'h08);
    applyStimulus(1'b1, 1'b0, 32'h0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("ignore_next_addr", {17'b0, imem_addr}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
